mips32_mem_responder: RTL and testbench

//  Memory-side responder for the MIPS32 core's data/instruction memory port.

---
 rtl/mips32_mem_responder.sv | 215 +++++++++++++++++++++
 tb/tb_mips32_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_responder.sv
// ---------------------------------------------------------------------------
// mips32_mem_responder
//   Memory-side responder for the MIPS32 core's instruction/data port.
//   One word-addressed load/store is accepted at a time over a valid/ready
//   request handshake. It is held for WAIT_CYCLES wait states. The access
//   to the DEPTH x DATA_W array then happens on a single clock edge, and the
//   result is offered over a valid/ready response handshake.
//
// Ports
//   i_clk          system clock, all state on posedge
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    request present
//   o_req_ready    responder can accept a request (IDLE only)
//   i_req_we       1 = store, 0 = load
//   i_req_addr     word address (full width checked against DEPTH)
//   i_req_wdata    store data
//   o_resp_valid   response present
//   i_resp_ready   requester takes the response
//   o_resp_rdata   load data, 0 for stores and out-of-range accesses
//   o_resp_err     address >= DEPTH
//   o_busy         transaction in flight (state != IDLE)
// ---------------------------------------------------------------------------
module mips32_mem_responder #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_resp_valid,
   input  logic              i_resp_ready,
   output logic [DATA_W-1:0] o_resp_rdata,
   output logic              o_resp_err,
   output logic              o_busy
);

   localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LP_DEPTH  = ADDR_W'(DEPTH);
   // Counter value on the edge that completes the last wait state.
   localparam logic [3:0]        LP_LAST   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Storage is deliberately not reset; contents survive rst_n.
   logic [DATA_W-1:0] r_mem [0:DEPTH-1];

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_req_ready;
   logic              r_resp_valid;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;

   state_t            w_state_nxt;
   logic [3:0]        w_cnt_nxt;
   logic              w_req_ready_nxt;
   logic              w_resp_valid_nxt;
   logic [DATA_W-1:0] w_rdata_nxt;
   logic              w_err_nxt;
   logic              w_we_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [DATA_W-1:0] w_wdata_nxt;

   logic              w_access;
   logic              w_acc_we;
   logic [ADDR_W-1:0] w_acc_addr;
   logic [DATA_W-1:0] w_acc_wdata;
   logic              w_in_range;
   logic [IDX_W-1:0]  w_idx;
   logic              w_mem_we;

   // Next-state, handshake outputs and the single-edge access decision.
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_req_ready_nxt  = r_req_ready;
      w_resp_valid_nxt = r_resp_valid;
      w_rdata_nxt      = r_rdata;
      w_err_nxt        = r_err;
      w_we_nxt         = r_we;
      w_addr_nxt       = r_addr;
      w_wdata_nxt      = r_wdata;
      w_access         = 1'b0;
      w_acc_we         = r_we;
      w_acc_addr       = r_addr;
      w_acc_wdata      = r_wdata;
      w_in_range       = 1'b0;
      w_idx            = '0;
      w_mem_we         = 1'b0;

      case (r_state)
         S_IDLE: begin
            // Ready rises on the first edge after reset release.
            w_req_ready_nxt = 1'b1;
            if (i_req_valid && r_req_ready) begin
               w_we_nxt        = i_req_we;
               w_addr_nxt      = i_req_addr;
               w_wdata_nxt     = i_req_wdata;
               w_req_ready_nxt = 1'b0;
               w_cnt_nxt       = 4'd0;
               if (WAIT_CYCLES == 0) begin
                  // No wait states: access straight from the request bus.
                  w_access    = 1'b1;
                  w_acc_we    = i_req_we;
                  w_acc_addr  = i_req_addr;
                  w_acc_wdata = i_req_wdata;
                  w_state_nxt = S_RESP;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            w_req_ready_nxt = 1'b0;
            w_cnt_nxt       = r_cnt + 4'd1;
            if (r_cnt == LP_LAST) begin
               w_access    = 1'b1;
               w_state_nxt = S_RESP;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         S_RESP: begin
            w_req_ready_nxt = 1'b0;
            if (r_resp_valid && i_resp_ready) begin
               w_state_nxt      = S_IDLE;
               w_resp_valid_nxt = 1'b0;
               w_rdata_nxt      = '0;
               w_err_nxt        = 1'b0;
               w_req_ready_nxt  = 1'b1;
            end else begin
               w_state_nxt = S_RESP;
            end
         end
         default: begin
            w_state_nxt      = S_IDLE;
            w_req_ready_nxt  = 1'b0;
            w_resp_valid_nxt = 1'b0;
            w_rdata_nxt      = '0;
            w_err_nxt        = 1'b0;
         end
      endcase

      // Range check uses the whole address, so high bits can never alias.
      w_in_range = (w_acc_addr < LP_DEPTH);
      w_idx      = w_acc_addr[IDX_W-1:0];
      if (w_access) begin
         w_resp_valid_nxt = 1'b1;
         w_err_nxt        = ~w_in_range;
         w_mem_we         = w_acc_we & w_in_range;
         if (!w_acc_we && w_in_range) begin
            w_rdata_nxt = r_mem[w_idx];
         end else begin
            w_rdata_nxt = '0;
         end
      end else begin
         w_mem_we = 1'b0;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_rdata      <= '0;
         r_err        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_req_ready  <= w_req_ready_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_rdata      <= w_rdata_nxt;
         r_err        <= w_err_nxt;
         r_we         <= w_we_nxt;
         r_addr       <= w_addr_nxt;
         r_wdata      <= w_wdata_nxt;
      end
   end

   // Array write port; w_mem_we is 0 while in reset because state is IDLE
   // and ready is low, so a reset never lets a pending store through.
   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         r_mem[w_idx] <= w_acc_wdata;
      end
   end

   assign o_req_ready  = r_req_ready;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_rdata;
   assign o_resp_err   = r_err;
   assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Directed bench for mips32_mem_responder: one instance with two wait
// states (dut_a) and one with none (dut_b).
module tb_mips32_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err, a_busy;
   logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
   logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err, b_busy;
   logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

   int n_checks = 0;
   int n_errs   = 0;

   logic [31:0] rd;
   logic        er;
   int          lat;

   mips32_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(2)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_we(a_req_we),
      .i_req_addr(a_req_addr), .i_req_wdata(a_req_wdata),
      .o_resp_valid(a_resp_valid), .i_resp_ready(a_resp_ready),
      .o_resp_rdata(a_resp_rdata), .o_resp_err(a_resp_err), .o_busy(a_busy)
   );

   mips32_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_we(b_req_we),
      .i_req_addr(b_req_addr), .i_req_wdata(b_req_wdata),
      .o_resp_valid(b_resp_valid), .i_resp_ready(b_resp_ready),
      .o_resp_rdata(b_resp_rdata), .o_resp_err(b_resp_err), .o_busy(b_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full transaction on dut_a with resp_ready held high; lat counts edges
   // from the accept edge (inclusive) to the edge raising resp_valid.
   task automatic a_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lt);
      a_resp_ready = 1'b1;
      a_req_valid  = 1'b1;
      a_req_we     = we;
      a_req_addr   = addr;
      a_req_wdata  = wdata;
      tick();
      a_req_valid = 1'b0;
      lt = 1;
      while (!a_resp_valid && lt < 10) begin
         tick();
         lt++;
      end
      rdata = a_resp_rdata;
      err   = a_resp_err;
      tick();
   endtask

   task automatic b_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lt);
      b_resp_ready = 1'b1;
      b_req_valid  = 1'b1;
      b_req_we     = we;
      b_req_addr   = addr;
      b_req_wdata  = wdata;
      tick();
      b_req_valid = 1'b0;
      lt = 1;
      while (!b_resp_valid && lt < 10) begin
         tick();
         lt++;
      end
      rdata = b_resp_rdata;
      err   = b_resp_err;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'd0; a_req_wdata = 32'd0; a_resp_ready = 1'b0;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'd0; b_req_wdata = 32'd0; b_resp_ready = 1'b0;
      #1;
      dut_a.r_mem[200]  = 32'd7;
      dut_a.r_mem[198]  = 32'h0000_1111;
      dut_a.r_mem[0]    = 32'hA5A5_0000;
      dut_a.r_mem[10]   = 32'h0000_0BAD;
      dut_a.r_mem[1023] = 32'h0000_03FF;
      dut_b.r_mem[5]    = 32'h1443_1000;

      // Reset values
      tick(); tick();
      chk("rst_ctrl_a", {28'd0, a_req_ready, a_resp_valid, a_resp_err, a_busy}, 32'd0);
      chk("rst_rdata_a", a_resp_rdata, 32'd0);
      chk("rst_ctrl_b", {28'd0, b_req_ready, b_resp_valid, b_resp_err, b_busy}, 32'd0);
      rst_n = 1'b1;
      chk("ready_at_release", {31'd0, a_req_ready}, 32'd0);
      tick();
      chk("ready_first_edge", {31'd0, a_req_ready}, 32'd1);

      // 1: load 200, W=2, cycle by cycle
      a_resp_ready = 1'b1;
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'd200;
      tick();
      a_req_valid = 1'b0;
      chk("t1_e1_valid_busy_ready", {29'd0, a_resp_valid, a_busy, a_req_ready}, 32'b010);
      tick();
      chk("t1_e2_valid", {31'd0, a_resp_valid}, 32'd0);
      tick();
      chk("t1_e3_valid", {31'd0, a_resp_valid}, 32'd1);
      chk("t1_rdata", a_resp_rdata, 32'd7);
      chk("t1_err", {31'd0, a_resp_err}, 32'd0);
      tick();
      chk("t1_after_take", {29'd0, a_resp_valid, a_busy, a_req_ready}, 32'b001);
      chk("t1_rdata_clr", a_resp_rdata, 32'd0);

      // 2: store then load same address
      a_txn(1'b1, 32'd198, 32'd5040, rd, er, lat);
      chk("t2_store_rdata", rd, 32'd0);
      chk("t2_store_err", {31'd0, er}, 32'd0);
      chk("t2_store_lat", lat, 32'd3);
      a_txn(1'b0, 32'd198, 32'd0, rd, er, lat);
      chk("t2_load_rdata", rd, 32'd5040);

      // 3: W=0 load of 5
      b_resp_ready = 1'b1;
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'd5;
      tick();
      b_req_valid = 1'b0;
      chk("t3_valid_1cyc", {30'd0, b_resp_valid, b_req_ready}, 32'b10);
      chk("t3_rdata", b_resp_rdata, 32'h1443_1000);
      tick();
      chk("t3_ready_back", {30'd0, b_resp_valid, b_req_ready}, 32'b01);
      b_txn(1'b1, 32'd6, 32'h55, rd, er, lat);
      chk("t3_store_lat", lat, 32'd1);
      b_txn(1'b0, 32'd6, 32'd0, rd, er, lat);
      chk("t3_load_back", rd, 32'h55);

      // 4: back-pressure on response; req_* wiggled while busy is ignored
      a_resp_ready = 1'b0;
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'd200;
      tick();
      a_req_we = 1'b1; a_req_addr = 32'd0; a_req_wdata = 32'hFFFF_FFFF;
      tick();
      a_req_valid = 1'b0;
      tick();
      chk("t4_valid_rise", {31'd0, a_resp_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_ctrl", {30'd0, a_resp_valid, a_req_ready}, 32'b10);
         chk("t4_hold_rdata", a_resp_rdata, 32'd7);
      end
      a_resp_ready = 1'b1;
      tick();
      chk("t4_released", {30'd0, a_resp_valid, a_req_ready}, 32'b01);
      tick();
      chk("t4_no_dup", {31'd0, a_resp_valid}, 32'd0);

      // 5: out-of-range accesses and the top in-range word
      a_txn(1'b1, 32'd1024, 32'h1234_5678, rd, er, lat);
      chk("t5_st_err", {31'd0, er}, 32'd1);
      chk("t5_st_rdata", rd, 32'd0);
      a_txn(1'b0, 32'hFFFF_FFFF, 32'd0, rd, er, lat);
      chk("t5_ld_err", {31'd0, er}, 32'd1);
      chk("t5_ld_rdata", rd, 32'd0);
      a_txn(1'b0, 32'd0, 32'd0, rd, er, lat);
      chk("t5_mem0_kept", rd, 32'hA5A5_0000);
      a_txn(1'b0, 32'd1023, 32'd0, rd, er, lat);
      chk("t5_top_word", {er, rd[30:0]}, 32'h0000_03FF);

      // 6: reset during WAIT discards the store
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'd10; a_req_wdata = 32'h0000_DEAD;
      tick();
      a_req_valid = 1'b0;
      chk("t6_in_wait", {31'd0, a_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ctrl", {28'd0, a_req_ready, a_resp_valid, a_resp_err, a_busy}, 32'd0);
      chk("t6_rst_rdata", a_resp_rdata, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("t6_mem_kept", dut_a.r_mem[10], 32'h0000_0BAD);
      a_txn(1'b0, 32'd10, 32'd0, rd, er, lat);
      chk("t6_load_old", rd, 32'h0000_0BAD);

      // Reset while in RESP drops the response at once
      a_resp_ready = 1'b0;
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'd200;
      tick();
      a_req_valid = 1'b0;
      tick(); tick();
      chk("t7_resp_up", {31'd0, a_resp_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t7_resp_dropped", {30'd0, a_resp_valid, a_busy}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
